// File: rtl/arena_pkg.sv
// arena_pkg: shared definitions for the double-buffered Life arena.
//   - Default geometry (cells per row, rows per bank) and generation counter width.
//   - FSM state encoding used by arena_dbuf.
package arena_pkg;

  localparam int DEF_WIDTH    = 10;
  localparam int DEF_HEIGHT   = 10;
  localparam int DEF_ROW_BITS = 10;
  localparam int DEF_GEN_BITS = 16;

  // ST_CLEAR: sequencer is zeroing both banks; ST_READY: normal operation.
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage

// File: rtl/arena_bank.sv
// arena_bank: one bank of the arena. Single-clock RAM of HEIGHT rows x WIDTH
// bits with two registered read ports and one write port.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset (clears read registers)
//   rd_en[1:0]         per-port read enable; a disabled port registers 0
//   rd_row[1:0]        per-port read row address
//   rd_data[1:0]       per-port read data, 1-cycle latency
//   wr_en/wr_row/wr_data  write port
// Out-of-range rows (>= HEIGHT) read as 0 and writes to them are dropped, so a
// truncated RAM index can never alias onto a real row.
module arena_bank #(
  parameter int WIDTH    = 10,
  parameter int HEIGHT   = 10,
  parameter int ROW_BITS = 10
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [1:0]                     rd_en,
  input  logic [1:0][ROW_BITS-1:0]       rd_row,
  output logic [1:0][WIDTH-1:0]          rd_data,
  input  logic                           wr_en,
  input  logic [ROW_BITS-1:0]            wr_row,
  input  logic [WIDTH-1:0]               wr_data
);

  localparam int IDX_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  logic [WIDTH-1:0] mem [HEIGHT];
  logic [1:0]       rd_ok;
  logic             wr_ok;

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd_guard
    assign rd_ok[gi] = rd_en[gi] && (rd_row[gi] < ROW_BITS'(HEIGHT));
  end

  assign wr_ok = wr_en && (wr_row < ROW_BITS'(HEIGHT));

  // RAM array kept free of reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_row[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        rd_data[i] <= '0;
      end else if (rd_ok[i]) begin
        rd_data[i] <= mem[rd_row[i][IDX_W-1:0]];
      end else begin
        rd_data[i] <= '0;
      end
    end
  end

endmodule

// File: rtl/arena_dbuf.sv
// arena_dbuf: ping-pong Life arena memory. Two banks of HEIGHT rows x WIDTH bits;
// the display and engine read the current bank, the engine writes the next bank,
// and a swap flips the roles. A clear sequencer zeroes both banks after reset
// and on request.
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   disp_row / disp_columns_out      display read port (current bank, 1-cycle latency)
//   eng_row / eng_columns_out        engine read port (current bank, 1-cycle latency)
//   eng_wr_row, eng_columns_in, eng_write   engine write into next bank
//   swap_req                         pulse: next bank becomes current
//   clear_req                        pulse: zero both banks
//   busy                             high while resetting/clearing
//   gen_count                        swaps completed since last clear (wraps)
module arena_dbuf
  import arena_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int HEIGHT   = DEF_HEIGHT,
  parameter int ROW_BITS = DEF_ROW_BITS,
  parameter int GEN_BITS = DEF_GEN_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ROW_BITS-1:0] disp_row,
  output logic [WIDTH-1:0]    disp_columns_out,
  input  logic [ROW_BITS-1:0] eng_row,
  output logic [WIDTH-1:0]    eng_columns_out,
  input  logic [ROW_BITS-1:0] eng_wr_row,
  input  logic [WIDTH-1:0]    eng_columns_in,
  input  logic                eng_write,
  input  logic                swap_req,
  input  logic                clear_req,
  output logic                busy,
  output logic [GEN_BITS-1:0] gen_count
);

  state_t              state_reg, state_next;
  logic [ROW_BITS-1:0] clr_row_reg, clr_row_next;
  logic                bank_sel_reg, bank_sel_next;
  logic [GEN_BITS-1:0] gen_count_reg, gen_count_next;

  // Port 0 = display, port 1 = engine, per bank.
  logic [1:0][WIDTH-1:0] bank_q [2];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= ST_CLEAR;
      clr_row_reg   <= '0;
      bank_sel_reg  <= 1'b0;
      gen_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      clr_row_reg   <= clr_row_next;
      bank_sel_reg  <= bank_sel_next;
      gen_count_reg <= gen_count_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    clr_row_next   = clr_row_reg;
    bank_sel_next  = bank_sel_reg;
    gen_count_next = gen_count_reg;
    case (state_reg)
      ST_CLEAR: begin
        if (clr_row_reg == ROW_BITS'(HEIGHT - 1)) begin
          state_next   = ST_READY;
          clr_row_next = '0;
        end else begin
          clr_row_next = clr_row_reg + 1'b1;
        end
      end
      ST_READY: begin
        // Clear takes priority over a coincident swap.
        if (clear_req) begin
          state_next     = ST_CLEAR;
          clr_row_next   = '0;
          bank_sel_next  = 1'b0;
          gen_count_next = '0;
        end else if (swap_req) begin
          bank_sel_next  = ~bank_sel_reg;
          gen_count_next = gen_count_reg + 1'b1;
        end
      end
    endcase
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    logic                rd_en;
    logic                wr_en;
    logic [ROW_BITS-1:0] wr_row;
    logic [WIDTH-1:0]    wr_data;

    // Only the current bank is read-enabled, so the other bank's read
    // registers hold 0 and the two outputs can simply be ORed. The enable is
    // decided from bank_sel at issue time, so a read alongside a swap still
    // sees the pre-swap bank.
    always_comb begin
      rd_en = (state_reg == ST_READY) && (bank_sel_reg == 1'(gi));
      if (state_reg == ST_CLEAR) begin
        wr_en   = 1'b1;
        wr_row  = clr_row_reg;
        wr_data = '0;
      end else begin
        wr_en   = eng_write && (bank_sel_reg != 1'(gi));
        wr_row  = eng_wr_row;
        wr_data = eng_columns_in;
      end
    end

    arena_bank #(
      .WIDTH   (WIDTH),
      .HEIGHT  (HEIGHT),
      .ROW_BITS(ROW_BITS)
    ) u_bank (
      .clk    (clk),
      .rst_n  (rst_n),
      .rd_en  ({rd_en, rd_en}),
      .rd_row ({eng_row, disp_row}),
      .rd_data(bank_q[gi]),
      .wr_en  (wr_en),
      .wr_row (wr_row),
      .wr_data(wr_data)
    );
  end

  assign disp_columns_out = bank_q[0][0] | bank_q[1][0];
  assign eng_columns_out  = bank_q[0][1] | bank_q[1][1];
  assign busy             = (state_reg == ST_CLEAR);
  assign gen_count        = gen_count_reg;

endmodule

// File: tb/tb_arena_dbuf.sv
// tb_arena_dbuf: directed bench for arena_dbuf with hand-computed expectations.
// Built with GEN_BITS=4 so the generation counter wrap can be reached quickly.
module tb_arena_dbuf;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int RB = 10;
  localparam int GB = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [RB-1:0] disp_row, eng_row, eng_wr_row;
  logic [W-1:0]  disp_columns_out, eng_columns_out, eng_columns_in;
  logic          eng_write, swap_req, clear_req, busy;
  logic [GB-1:0] gen_count;

  int n_checks = 0;
  int n_errors = 0;
  int cnt;
  logic [W-1:0] want [H];

  arena_dbuf #(
    .WIDTH   (W),
    .HEIGHT  (H),
    .ROW_BITS(RB),
    .GEN_BITS(GB)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .disp_row        (disp_row),
    .disp_columns_out(disp_columns_out),
    .eng_row         (eng_row),
    .eng_columns_out (eng_columns_out),
    .eng_wr_row      (eng_wr_row),
    .eng_columns_in  (eng_columns_in),
    .eng_write       (eng_write),
    .swap_req        (swap_req),
    .clear_req       (clear_req),
    .busy            (busy),
    .gen_count       (gen_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, got, exp);
    end else begin
      $display("chk %s ok %0h", tag, got);
    end
  endtask

  // One clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [RB-1:0] row);
    disp_row = row;
    eng_row  = row;
    step();
  endtask

  task automatic scan(input string tag);
    for (int r = 0; r < H; r++) begin
      rd(RB'(r));
      chk($sformatf("%s_d%0d", tag, r), disp_columns_out, want[r]);
      chk($sformatf("%s_e%0d", tag, r), eng_columns_out, want[r]);
    end
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      step();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; disp_row = '0; eng_row = '0; eng_wr_row = '0;
    eng_columns_in = '0; eng_write = 1'b0; swap_req = 1'b0; clear_req = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 1);
    chk("rst_gen", gen_count, 0);
    chk("rst_disp", disp_columns_out, 0);
    chk("rst_eng", eng_columns_out, 0);

    rst_n = 1'b1;
    busy_len(cnt);
    chk("rst_busy_len", cnt, H);
    chk("rst_gen2", gen_count, 0);
    for (int r = 0; r < H; r++) want[r] = '0;
    scan("rst");

    // Write row 3 into the next bank (bank 1), then swap.
    eng_wr_row = 10'd3; eng_columns_in = 10'h155; eng_write = 1'b1;
    step();
    eng_write = 1'b0;
    rd(10'd3);
    chk("pre_swap", disp_columns_out, 0);
    swap_req = 1'b1;
    rd(10'd3);
    swap_req = 1'b0;
    chk("same_cyc_swap", disp_columns_out, 0);
    rd(10'd3);
    chk("post_swap_d", disp_columns_out, 10'h155);
    chk("post_swap_e", eng_columns_out, 10'h155);
    chk("gen1", gen_count, 1);

    // Write + swap together: write lands in bank 0, which becomes current.
    eng_wr_row = 10'd5; eng_columns_in = 10'h3FF; eng_write = 1'b1; swap_req = 1'b1;
    step();
    eng_write = 1'b0; swap_req = 1'b0;
    rd(10'd5);
    chk("ws_row5_d", disp_columns_out, 10'h3FF);
    chk("ws_row5_e", eng_columns_out, 10'h3FF);
    rd(10'd3);
    chk("ws_row3", disp_columns_out, 0);
    chk("gen2", gen_count, 2);
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    rd(10'd5);
    chk("b1_row5", disp_columns_out, 0);
    rd(10'd3);
    chk("b1_row3", disp_columns_out, 10'h155);
    chk("gen3", gen_count, 3);

    // Out-of-range write into bank 0, then swap to bank 0.
    eng_wr_row = 10'd12; eng_columns_in = 10'h0AA; eng_write = 1'b1;
    step();
    eng_write = 1'b0;
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    want[5] = 10'h3FF;
    scan("oor");
    rd(10'd12);
    chk("oor_rd_d", disp_columns_out, 0);
    chk("oor_rd_e", eng_columns_out, 0);
    chk("gen4", gen_count, 4);

    // Fifth swap: bank 1 current again, with row 3 populated.
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    chk("gen5", gen_count, 5);
    rd(10'd3);
    chk("pre_clr_row3", disp_columns_out, 10'h155);

    // Clear together with swap; keep writing/swapping while busy.
    clear_req = 1'b1; swap_req = 1'b1;
    step();
    clear_req = 1'b0;
    eng_write = 1'b1; eng_wr_row = 10'd0; eng_columns_in = 10'h3FF;
    busy_len(cnt);
    eng_write = 1'b0; swap_req = 1'b0;
    chk("clr_busy_len", cnt, H);
    chk("clr_gen", gen_count, 0);
    for (int r = 0; r < H; r++) want[r] = '0;
    scan("clr_b0");
    swap_req = 1'b1;
    step();
    swap_req = 1'b0;
    scan("clr_b1");
    chk("clr_gen1", gen_count, 1);

    // Counter wrap: 14 more swaps -> 15, then 2 more -> 17 total -> 1.
    swap_req = 1'b1;
    repeat (14) step();
    swap_req = 1'b0;
    chk("gen15", gen_count, 4'hF);
    swap_req = 1'b1;
    repeat (2) step();
    swap_req = 1'b0;
    chk("gen_wrap", gen_count, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
